// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock sequencer: state encoding and retry counter width.
package pll_seq_pkg;

  localparam int RETRY_W = 4;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  // States in which the PLL itself is held in reset.
  function automatic logic holds_pll_reset(input pll_state_e s);
    return (s == PLL_RST) || (s == FAULT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with synchronous clear, for any input that is
// asynchronous to clk.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability chain: first flop may go metastable, second presents a settled value.
  always_ff @(posedge clk) begin
    if (clr) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds the PLL in reset, waits for a stable lock, then releases the system reset;
// re-sequences on loss of lock and retries on timeout until a retry budget runs out.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               retry_req,
  output logic               pll_reset,
  output logic               sys_rst,
  output logic               ready,
  output logic               fault,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_ZERO  = {RETRY_W{1'b0}};
  localparam logic [RETRY_W-1:0] RETRY_ONE   = {{(RETRY_W-1){1'b0}}, 1'b1};
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  pll_state_e         state_r;
  pll_state_e         state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [RETRY_W-1:0] retry_cnt_r;
  logic [RETRY_W-1:0] retry_nxt_s;
  logic               locked_s;

  logic pll_reset_r, sys_rst_r, ready_r, fault_r, lock_lost_r;
  logic pll_reset_nxt_s, sys_rst_nxt_s, ready_nxt_s, fault_nxt_s, lock_lost_nxt_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clk),
    .clr (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Next-state, shared counter and retry bookkeeping.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    retry_nxt_s = retry_cnt_r;
    case (state_r)
      PLL_RST: begin
        if (cnt_r == RST_LAST) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        // Lock has priority over a coincident timeout.
        if (locked_s) begin
          state_nxt_s = STABLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == TIMEOUT_LAST) begin
          cnt_nxt_s = CNT_ZERO;
          if (retry_cnt_r >= RETRY_MAX) begin
            state_nxt_s = FAULT;
          end else begin
            state_nxt_s = PLL_RST;
            retry_nxt_s = retry_cnt_r + RETRY_ONE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == STABLE_LAST) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ZERO;
          retry_nxt_s = RETRY_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt_s = PLL_RST;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = CNT_ZERO;
        end
      end
      FAULT: begin
        if (retry_req) begin
          state_nxt_s = PLL_RST;
          cnt_nxt_s   = CNT_ZERO;
          retry_nxt_s = RETRY_ZERO;
        end else begin
          cnt_nxt_s = CNT_ZERO;
        end
      end
      default: begin
        // Illegal encoding: restart the whole sequence from a safe state.
        state_nxt_s = PLL_RST;
        cnt_nxt_s   = CNT_ZERO;
        retry_nxt_s = RETRY_ZERO;
      end
    endcase
  end

  // Output decode from next-state so outputs switch on the same edge as the state.
  always_comb begin
    pll_reset_nxt_s = holds_pll_reset(state_nxt_s);
    sys_rst_nxt_s   = (state_nxt_s != RUN);
    ready_nxt_s     = (state_nxt_s == RUN);
    fault_nxt_s     = (state_nxt_s == FAULT);
    lock_lost_nxt_s = (state_r == RUN) && (state_nxt_s == PLL_RST);
  end

  // State, counter, retry count and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= PLL_RST;
      cnt_r       <= CNT_ZERO;
      retry_cnt_r <= RETRY_ZERO;
      pll_reset_r <= 1'b1;
      sys_rst_r   <= 1'b1;
      ready_r     <= 1'b0;
      fault_r     <= 1'b0;
      lock_lost_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      retry_cnt_r <= retry_nxt_s;
      pll_reset_r <= pll_reset_nxt_s;
      sys_rst_r   <= sys_rst_nxt_s;
      ready_r     <= ready_nxt_s;
      fault_r     <= fault_nxt_s;
      lock_lost_r <= lock_lost_nxt_s;
    end
  end

  assign pll_reset = pll_reset_r;
  assign sys_rst   = sys_rst_r;
  assign ready     = ready_r;
  assign fault     = fault_r;
  assign lock_lost = lock_lost_r;
  assign retry_cnt = retry_cnt_r;
  assign state_o   = state_r;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus random lock/retry/reset traffic,
// all checked every cycle against a phase/elapsed-time reference model.
module tb_pll_lock_sequencer;

  localparam int RST_C = 4;
  localparam int TO_C  = 32;
  localparam int ST_C  = 8;
  localparam int MAXR  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       retry_req = 1'b0;
  logic       pll_reset, sys_rst, ready, fault, lock_lost;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;

  pll_lock_sequencer #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (TO_C),
    .STABLE_CYCLES(ST_C),
    .MAX_RETRIES  (MAXR),
    .CNT_W        (17)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .retry_req  (retry_req),
    .pll_reset  (pll_reset),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: current phase, edge at which it was entered, retries used,
  // and a two-deep history of the sampled lock input.
  int m_phase = 0;
  int m_enter = 0;
  int m_retry = 0;
  bit m_lost = 1'b0;
  bit m_hist1 = 1'b0;
  bit m_hist2 = 1'b0;
  bit cur_lock = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input bit r, input bit l, input bit q);
    bit ls;
    int el;
    int np;
    if (r) begin
      m_phase = 0;
      m_enter = cyc;
      m_retry = 0;
      m_lost  = 1'b0;
      m_hist1 = 1'b0;
      m_hist2 = 1'b0;
    end else begin
      ls = m_hist2;
      el = (cyc - 1) - m_enter;
      np = m_phase;
      m_lost = 1'b0;
      case (m_phase)
        0: if (el == RST_C - 1) np = 1;
        1: begin
          if (ls) np = 2;
          else if (el == TO_C - 1) begin
            if (m_retry == MAXR) np = 4;
            else begin
              m_retry++;
              np = 0;
            end
          end
        end
        2: begin
          if (!ls) np = 1;
          else if (el == ST_C - 1) begin
            np = 3;
            m_retry = 0;
          end
        end
        3: if (!ls) begin
          np = 0;
          m_lost = 1'b1;
        end
        4: if (q) begin
          np = 0;
          m_retry = 0;
        end
        default: np = 0;
      endcase
      if (np != m_phase) m_enter = cyc;
      m_phase = np;
      m_hist2 = m_hist1;
      m_hist1 = l;
    end
  endtask

  task automatic compare_all();
    chk("state_o",   int'(state_o),   m_phase);
    chk("pll_reset", int'(pll_reset), int'(m_phase == 0 || m_phase == 4));
    chk("sys_rst",   int'(sys_rst),   int'(m_phase != 3));
    chk("ready",     int'(ready),     int'(m_phase == 3));
    chk("fault",     int'(fault),     int'(m_phase == 4));
    chk("lock_lost", int'(lock_lost), int'(m_lost));
    chk("retry_cnt", int'(retry_cnt), m_retry);
  endtask

  task automatic cycle(input bit r, input bit q);
    rst        = r;
    pll_locked = cur_lock;
    retry_req  = q;
    @(posedge clk);
    cyc++;
    #1;
    model_step(r, cur_lock, q);
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle(1'b0, 1'b0);
  endtask

  initial begin
    int hold;
    bit r;
    bit q;

    // Reset and clean lock
    cur_lock = 1'b0;
    repeat (3) cycle(1'b1, 1'b0);
    chk("reset_state", int'(state_o), 0);
    chk("reset_pll_reset", int'(pll_reset), 1);
    run(3);
    chk("pll_reset_held", int'(pll_reset), 1);
    run(1);
    chk("pll_reset_released", int'(pll_reset), 0);
    chk("wait_lock_entered", int'(state_o), 1);
    cur_lock = 1'b1;
    run(10);
    chk("ready_not_before_11", int'(ready), 0);
    run(1);
    chk("ready_on_11th", int'(ready), 1);
    chk("sys_rst_on_11th", int'(sys_rst), 0);
    run(3);

    // Loss of lock in RUN
    cur_lock = 1'b0;
    run(2);
    chk("lock_lost_early", int'(lock_lost), 0);
    run(1);
    chk("lock_lost_pulse", int'(lock_lost), 1);
    chk("lost_sys_rst", int'(sys_rst), 1);
    chk("lost_pll_reset", int'(pll_reset), 1);
    run(1);
    chk("lock_lost_single", int'(lock_lost), 0);
    run(2);
    chk("relock_pll_reset_4", int'(pll_reset), 1);
    run(1);
    chk("relock_pll_reset_low", int'(pll_reset), 0);

    // Debounce break: 5 high, 1 low, then high
    cur_lock = 1'b1;
    run(5);
    cur_lock = 1'b0;
    run(1);
    cur_lock = 1'b1;
    run(10);
    chk("debounce_not_ready", int'(ready), 0);
    run(1);
    chk("debounce_ready", int'(ready), 1);

    // Timeouts, retries, FAULT
    cur_lock = 1'b0;
    cycle(1'b1, 1'b0);
    for (int att = 0; att < 3; att++) begin
      run(3);
      chk("retry_pll_reset", int'(pll_reset), 1);
      run(1);
      chk("retry_wait", int'(state_o), 1);
      run(31);
      chk("wait_before_timeout", int'(state_o), 1);
      run(1);
      if (att < 2) begin
        chk("timeout_to_pll_rst", int'(state_o), 0);
        chk("timeout_retry_cnt", int'(retry_cnt), att + 1);
      end else begin
        chk("fault_state", int'(state_o), 4);
        chk("fault_flag", int'(fault), 1);
        chk("fault_pll_reset", int'(pll_reset), 1);
      end
    end
    run(5);
    chk("fault_hold", int'(fault), 1);
    cycle(1'b0, 1'b1);
    chk("retry_req_state", int'(state_o), 0);
    chk("retry_req_cnt", int'(retry_cnt), 0);

    // Lock arriving exactly on the timeout cycle
    run(4);
    run(32);
    chk("corner_retry_1", int'(retry_cnt), 1);
    run(4);
    run(29);
    cur_lock = 1'b1;
    run(2);
    chk("corner_still_wait", int'(state_o), 1);
    run(1);
    chk("corner_stable", int'(state_o), 2);
    chk("corner_retry_kept", int'(retry_cnt), 1);

    // Reset mid-STABLE
    run(3);
    cycle(1'b1, 1'b0);
    chk("midrst_state", int'(state_o), 0);
    chk("midrst_pll_reset", int'(pll_reset), 1);
    chk("midrst_sys_rst", int'(sys_rst), 1);
    chk("midrst_retry", int'(retry_cnt), 0);

    // Random traffic
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        cur_lock = ($urandom_range(0, 1) == 1);
        hold = $urandom_range(1, 50);
      end
      hold--;
      r = ($urandom_range(0, 499) == 0);
      q = ($urandom_range(0, 19) == 0);
      cycle(r, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
